// File: rtl/audio_separate.sv
// Receive-side splitter: composite baseband -> channel 1 (boxcar low-pass) and
// channel 2 (high-pass, rectify, integrate-and-dump envelope, DC removal).
module audio_separate #(
  parameter int DATA_WIDTH = 12,
  parameter int LPF_LOG2   = 4,
  parameter int ENV_LOG2   = 5,
  parameter int DC_SHIFT   = 4
) (
  input  logic                         clk_in,
  input  logic                         RST,
  input  logic signed [DATA_WIDTH-1:0] Demod_SIG,
  input  logic                         SIG_valid,
  output logic signed [DATA_WIDTH-1:0] Audio_CH1,
  output logic                         CH1_valid,
  output logic signed [DATA_WIDTH-1:0] Audio_CH2,
  output logic                         CH2_valid,
  output logic        [DATA_WIDTH-1:0] Env_level
);

  localparam int N  = 1 << LPF_LOG2;
  localparam int SW = DATA_WIDTH + LPF_LOG2;   // running sum
  localparam int HW = DATA_WIDTH + 1;          // high-pass sample
  localparam int AW = DATA_WIDTH + ENV_LOG2;   // envelope accumulator
  localparam int DW = DATA_WIDTH + 2;          // envelope minus DC
  localparam logic [LPF_LOG2-1:0]  HALF     = LPF_LOG2'(N / 2);
  localparam logic [DATA_WIDTH-1:0] RECT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_HI   = DW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [DW-1:0] SAT_LO   = ~SAT_HI;

  // Stage A state
  logic signed [DATA_WIDTH-1:0] dly_buf [N];
  logic        [LPF_LOG2-1:0]   wr_ptr;
  logic signed [SW-1:0]         sum;
  logic signed [DATA_WIDTH-1:0] x_d;
  logic                         a_valid;
  // Stage B/C/D state
  logic signed [HW-1:0]         hp;
  logic        [AW-1:0]         acc;
  logic        [ENV_LOG2-1:0]   cnt;
  logic        [DATA_WIDTH-1:0] env;
  logic                         c_dump;
  logic signed [HW-1:0]         dc;

  logic signed [DATA_WIDTH-1:0] lp;
  logic        [HW-1:0]         abs_hp;
  logic        [DATA_WIDTH-1:0] rect;
  logic        [AW-1:0]         acc_sum;
  logic signed [DW-1:0]         env_diff;
  logic signed [DATA_WIDTH-1:0] ch2_sat;

  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    lp       = DATA_WIDTH'(sum >>> LPF_LOG2);
    abs_hp   = hp[HW-1] ? HW'(-hp) : HW'(hp);
    rect     = (abs_hp > HW'(RECT_MAX)) ? RECT_MAX : abs_hp[DATA_WIDTH-1:0];
    acc_sum  = acc + AW'(rect);
    env_diff = $signed({2'b00, env}) - DW'(dc);
    ch2_sat  = DATA_WIDTH'(env_diff);
    if (env_diff > SAT_HI)      ch2_sat = SAT_HI[DATA_WIDTH-1:0];
    else if (env_diff < SAT_LO) ch2_sat = SAT_LO[DATA_WIDTH-1:0];
  end

  // NOTE: the delay buffer is reset element by element because an unfilled
  // buffer must read as zero; this forces it into flops rather than RAM.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) dly_buf[i] <= '0;
      wr_ptr  <= '0;
      sum     <= '0;
      x_d     <= '0;
      a_valid <= 1'b0;
    end else begin
      a_valid <= SIG_valid;
      if (SIG_valid) begin
        dly_buf[wr_ptr] <= Demod_SIG;
        wr_ptr          <= wr_ptr + 1'b1;
        sum             <= sum + SW'(Demod_SIG) - SW'(dly_buf[wr_ptr]);
        x_d             <= dly_buf[wr_ptr + HALF];
      end
    end
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      Audio_CH1 <= '0;
      CH1_valid <= 1'b0;
      hp        <= '0;
    end else begin
      CH1_valid <= a_valid;
      if (a_valid) begin
        Audio_CH1 <= lp;
        hp        <= HW'(x_d) - HW'(lp);
      end
    end
  end

  // Integrate-and-dump: the window's last sample is folded into the dump value.
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      acc    <= '0;
      cnt    <= '0;
      env    <= '0;
      c_dump <= 1'b0;
    end else begin
      c_dump <= CH1_valid && (cnt == '1);
      if (CH1_valid) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) begin
          env <= DATA_WIDTH'(acc_sum >> ENV_LOG2);
          acc <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      Env_level <= '0;
      Audio_CH2 <= '0;
      CH2_valid <= 1'b0;
      dc        <= '0;
    end else begin
      CH2_valid <= c_dump;
      if (c_dump) begin
        Env_level <= env;
        Audio_CH2 <= ch2_sat;
        dc        <= dc + HW'(env_diff >>> DC_SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_audio_separate.sv
// Directed self-checking bench for audio_separate: reset, DC step, subcarrier,
// saturation, paced input and valid-during-reset scenarios.
`timescale 1ns/1ps
module tb_audio_separate;

  logic               clk_in = 1'b0;
  logic               RST = 1'b1;
  logic signed [11:0] Demod_SIG = '0;
  logic               SIG_valid = 1'b0;
  logic signed [11:0] Audio_CH1, Audio_CH2;
  logic               CH1_valid, CH2_valid;
  logic        [11:0] Env_level;

  audio_separate #(.DATA_WIDTH(12), .LPF_LOG2(4), .ENV_LOG2(5), .DC_SHIFT(4)) dut (
    .clk_in(clk_in), .RST(RST), .Demod_SIG(Demod_SIG), .SIG_valid(SIG_valid),
    .Audio_CH1(Audio_CH1), .CH1_valid(CH1_valid), .Audio_CH2(Audio_CH2),
    .CH2_valid(CH2_valid), .Env_level(Env_level)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  logic signed [11:0] ch1_q[$];
  logic signed [11:0] ch2_q[$];
  logic        [11:0] env_q[$];
  logic signed [11:0] ref_ch1[$];
  logic signed [11:0] ref_ch2[$];
  logic        [11:0] ref_env[$];
  bit  paced = 0;
  int  width_err = 0;
  logic prev1 = 0, prev2 = 0;

  always @(negedge clk_in) begin
    if (CH1_valid) ch1_q.push_back(Audio_CH1);
    if (CH2_valid) begin
      ch2_q.push_back(Audio_CH2);
      env_q.push_back(Env_level);
    end
    if (paced && ((CH1_valid && prev1) || (CH2_valid && prev2))) width_err++;
    prev1 = CH1_valid;
    prev2 = CH2_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Callers are aligned to a negedge; gap=1 gives back-to-back valids.
  task automatic send(input logic signed [11:0] x, input int gap);
    Demod_SIG = x;
    SIG_valid = 1'b1;
    @(negedge clk_in);
    SIG_valid = 1'b0;
    repeat (gap - 1) @(negedge clk_in);
  endtask

  task automatic clear_q();
    ch1_q.delete(); ch2_q.delete(); env_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    RST = 1'b1;
    SIG_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    RST = 1'b0;
    @(negedge clk_in);
    clear_q();
  endtask

  // Reference DC-removal IIR applied to a list of dump envelopes.
  function automatic int ch2_model(input int envs[], input int idx);
    int dc, diff, y;
    dc = 0; y = 0;
    for (int i = 0; i <= idx; i++) begin
      diff = envs[i] - dc;
      y = (diff > 2047) ? 2047 : ((diff < -2048) ? -2048 : diff);
      dc = dc + (diff >>> 4);
    end
    return y;
  endfunction

  task automatic check_ch2(input string name, input int envs[]);
    tests++;
    if (env_q.size() != envs.size()) begin
      fails++;
      $display("FAIL %s dump_count: got %0d expected %0d", name, env_q.size(), envs.size());
    end else begin
      for (int i = 0; i < envs.size(); i++) begin
        tests++;
        if (env_q[i] !== 12'(envs[i])) begin
          fails++;
          $display("FAIL %s env[%0d]: got %0d expected %0d", name, i, env_q[i], envs[i]);
        end
        tests++;
        if (ch2_q[i] !== 12'(ch2_model(envs, i))) begin
          fails++;
          $display("FAIL %s ch2[%0d]: got %0d expected %0d", name, i, ch2_q[i], ch2_model(envs, i));
        end
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    do_reset();
    tests++;
    if ({Audio_CH1, Audio_CH2, Env_level, CH1_valid, CH2_valid} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got CH1=%0d CH2=%0d env=%0d", Audio_CH1, Audio_CH2, Env_level);
    end
    for (int k = 0; k < 40; k++) send(12'sd1000, 1);
    repeat (4) @(negedge clk_in);
    tests++;
    if (Audio_CH1 !== 12'sd1000 || Env_level === 12'd0) begin
      fails++;
      $display("FAIL pre_reset_activity: CH1=%0d env=%0d expected CH1=1000 env!=0", Audio_CH1, Env_level);
    end
    @(posedge clk_in); #2;
    RST = 1'b1;
    #1;
    tests++;
    if ({Audio_CH1, Audio_CH2, Env_level, CH1_valid, CH2_valid} !== '0) begin
      fails++;
      $display("FAIL async_reset: got CH1=%0d CH2=%0d env=%0d expected all 0", Audio_CH1, Audio_CH2, Env_level);
    end
    @(negedge clk_in);
    RST = 1'b0;
    @(negedge clk_in);
    clear_q();
    for (int k = 0; k < 31; k++) send(12'sd300, 1);
    repeat (8) @(negedge clk_in);
    tests++;
    if (ch2_q.size() != 0) begin
      fails++;
      $display("FAIL no_dump_31: got %0d CH2 strobes expected 0", ch2_q.size());
    end
    Demod_SIG = 12'sd300;
    SIG_valid = 1'b1;
    @(posedge clk_in); #1;
    SIG_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk_in); #1;
      if (CH2_valid) begin lat = n; break; end
    end
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL ch2_latency: got %0d edges expected 3", lat);
    end
    @(negedge clk_in);
  endtask

  task automatic test_dc_step();
    logic signed [11:0] exp1;
    do_reset();
    for (int k = 0; k < 160; k++) send(12'sd400, 1);
    repeat (8) @(negedge clk_in);
    tests++;
    if (ch1_q.size() != 160) begin
      fails++;
      $display("FAIL dc_ch1_count: got %0d expected 160", ch1_q.size());
    end else begin
      for (int k = 0; k < 160; k++) begin
        exp1 = (k < 16) ? 12'(25 * (k + 1)) : 12'sd400;
        tests++;
        if (ch1_q[k] !== exp1) begin
          fails++;
          $display("FAIL dc_ch1[%0d]: got %0d expected %0d", k, ch1_q[k], exp1);
        end
      end
    end
    // first window: ramp-up transient sums to 1600 -> 50
    check_ch2("dc", '{50, 0, 0, 0, 0});
    tests++;
    if (ch2_q.size() == 5 && (ch2_q[1] !== -12'sd3 || ch2_q[4] !== 12'sd0)) begin
      fails++;
      $display("FAIL dc_ch2_hand: got %0d,%0d expected -3,0", ch2_q[1], ch2_q[4]);
    end
  endtask

  task automatic test_subcarrier(input int gap);
    logic signed [11:0] exp1;
    do_reset();
    width_err = 0;
    paced = (gap > 1);
    for (int k = 0; k < 256; k++) send((k % 2 == 0) ? 12'sd512 : -12'sd512, gap);
    repeat (8) @(negedge clk_in);
    paced = 0;
    tests++;
    if (ch1_q.size() != 256) begin
      fails++;
      $display("FAIL sub_ch1_count gap=%0d: got %0d expected 256", gap, ch1_q.size());
    end else begin
      for (int k = 0; k < 256; k++) begin
        exp1 = (k < 15 && k % 2 == 0) ? 12'sd32 : 12'sd0;
        tests++;
        if (ch1_q[k] !== exp1) begin
          fails++;
          $display("FAIL sub_ch1[%0d] gap=%0d: got %0d expected %0d", k, gap, ch1_q[k], exp1);
        end
      end
    end
    check_ch2("sub", '{384, 512, 512, 512, 512, 512, 512, 512});
    tests++;
    if (ch2_q.size() == 8 && (ch2_q[0] !== 12'sd384 || ch2_q[1] !== 12'sd488 || ch2_q[2] !== 12'sd458)) begin
      fails++;
      $display("FAIL sub_ch2_hand: got %0d,%0d,%0d expected 384,488,458", ch2_q[0], ch2_q[1], ch2_q[2]);
    end
    if (gap == 1) begin
      ref_ch1 = ch1_q; ref_ch2 = ch2_q; ref_env = env_q;
    end else begin
      tests++;
      if (ch1_q != ref_ch1 || ch2_q != ref_ch2 || env_q != ref_env) begin
        fails++;
        $display("FAIL paced_vs_full: sequences differ (ch1 %0d/%0d ch2 %0d/%0d)",
                 ch1_q.size(), ref_ch1.size(), ch2_q.size(), ref_ch2.size());
      end
      tests++;
      if (width_err != 0) begin
        fails++;
        $display("FAIL strobe_width: got %0d wide strobes expected 0", width_err);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [11:0] exp1;
    do_reset();
    for (int k = 0; k < 128; k++) send((k % 2 == 0) ? 12'sd2047 : -12'sd2048, 1);
    repeat (8) @(negedge clk_in);
    tests++;
    if (ch1_q.size() != 128) begin
      fails++;
      $display("FAIL sat_ch1_count: got %0d expected 128", ch1_q.size());
    end else begin
      for (int k = 0; k < 128; k++) begin
        exp1 = (k < 15 && k % 2 == 0) ? 12'sd127 : -12'sd1;
        tests++;
        if (ch1_q[k] !== exp1) begin
          fails++;
          $display("FAIL sat_ch1[%0d]: got %0d expected %0d", k, ch1_q[k], exp1);
        end
      end
    end
    // first window sum 49132 -> 1535; later windows clip every |hp| to 2047
    check_ch2("sat", '{1535, 2047, 2047, 2047});
  endtask

  task automatic test_valid_with_reset();
    @(negedge clk_in);
    RST = 1'b1;
    Demod_SIG = 12'sd400;
    SIG_valid = 1'b1;
    @(negedge clk_in);
    SIG_valid = 1'b0;
    RST = 1'b0;
    @(negedge clk_in);
    clear_q();
    for (int k = 0; k < 31; k++) send(12'sd0, 1);
    repeat (8) @(negedge clk_in);
    tests++;
    if (ch2_q.size() != 0 || ch1_q.size() != 31 || Audio_CH1 !== 12'sd0) begin
      fails++;
      $display("FAIL valid_in_reset: got ch2=%0d ch1=%0d CH1=%0d expected 0,31,0",
               ch2_q.size(), ch1_q.size(), Audio_CH1);
    end
    send(12'sd0, 1);
    repeat (8) @(negedge clk_in);
    tests++;
    if (ch2_q.size() != 1 || Env_level !== 12'd0) begin
      fails++;
      $display("FAIL window_restart: got %0d dumps env=%0d expected 1 dump env=0", ch2_q.size(), Env_level);
    end
  endtask

  initial begin
    test_reset();
    test_dc_step();
    test_subcarrier(1);
    test_saturation();
    test_subcarrier(7);
    test_valid_with_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
